// File: rtl/l1_ahb_mtx_in_stage_if.sv
// L1 AHB matrix input stage bundle: master-side address phase and
// matrix-side request, grant and routed data-phase response.
interface l1_ahb_mtx_in_stage_if;

    // Master-side AHB-Lite address phase
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;

    // Master-side response
    logic        HREADYOUTS;
    logic        HRESPS;

    // Request and address/control toward decoder and output stages
    logic        sel_m;
    logic [31:0] ADDR_M;
    logic [1:0]  TRANS_M;
    logic        WRITE_M;
    logic [2:0]  SIZE_M;
    logic [2:0]  BURST_M;
    logic [3:0]  PROT_M;
    logic        MASTLOCK_M;
    logic        held_tran;

    // Grant and data-phase response routed back by the output stage
    logic        active_trans;
    logic        readyout_m;
    logic        resp_m;

    modport slave (
        input  HSELS,
        input  HADDRS,
        input  HTRANSS,
        input  HWRITES,
        input  HSIZES,
        input  HBURSTS,
        input  HPROTS,
        input  HMASTLOCKS,
        input  HREADYS,
        output HREADYOUTS,
        output HRESPS,
        output sel_m,
        output ADDR_M,
        output TRANS_M,
        output WRITE_M,
        output SIZE_M,
        output BURST_M,
        output PROT_M,
        output MASTLOCK_M,
        output held_tran,
        input  active_trans,
        input  readyout_m,
        input  resp_m
    );

    modport master (
        output HSELS,
        output HADDRS,
        output HTRANSS,
        output HWRITES,
        output HSIZES,
        output HBURSTS,
        output HPROTS,
        output HMASTLOCKS,
        output HREADYS,
        input  HREADYOUTS,
        input  HRESPS,
        input  sel_m,
        input  ADDR_M,
        input  TRANS_M,
        input  WRITE_M,
        input  SIZE_M,
        input  BURST_M,
        input  PROT_M,
        input  MASTLOCK_M,
        input  held_tran,
        output active_trans,
        output readyout_m,
        output resp_m
    );

endinterface

// File: rtl/l1_ahb_mtx_in_stage.sv
// L1 AHB matrix per-master input stage: holds ungranted address phases.
// Option L1AHBMTX_SEQ_TO_NONSEQ_EN: held SEQ transfers re-issued as NONSEQ.
module l1_ahb_mtx_in_stage (
    input  logic HCLK,
    input  logic HRESETn,
    l1_ahb_mtx_in_stage_if.slave bus
);

    localparam logic [1:0] TR_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_ready;
    logic        w_resp;

    logic        r_held;
    logic [31:0] r_addr;
    logic [1:0]  r_trans;
    logic        r_write;
    logic [2:0]  r_size;
    logic [2:0]  r_burst;
    logic [3:0]  r_prot;
    logic        r_lock;

    logic        w_live_req;
    logic        w_load;
    logic [1:0]  w_held_trans;

    assign w_live_req = bus.HSELS & bus.HREADYS
                      & (bus.HTRANSS != TR_IDLE);

    // While a transfer is held HREADYS is low, so nothing new is captured.
    assign w_load = w_live_req & ~bus.active_trans & ~r_held;

`ifdef L1AHBMTX_SEQ_TO_NONSEQ_EN
    localparam logic [1:0] TR_NSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    assign w_held_trans = (r_trans == TR_SEQ) ? TR_NSEQ : r_trans;
`else
    assign w_held_trans = r_trans;
`endif

    // Holding register captures an address phase that was not granted.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_trans <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_lock  <= 1'b0;
        end else if (w_load) begin
            r_addr  <= bus.HADDRS;
            r_trans <= bus.HTRANSS;
            r_write <= bus.HWRITES;
            r_size  <= bus.HSIZES;
            r_burst <= bus.HBURSTS;
            r_prot  <= bus.HPROTS;
            r_lock  <= bus.HMASTLOCKS;
        end
    end

    // Holding valid: set on an ungranted request, cleared by the grant.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_held <= 1'b0;
        end else if (bus.active_trans) begin
            r_held <= 1'b0;
        end else if (w_load) begin
            r_held <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and master-facing response; a completing data phase
    // is evaluated as IDLE so pipelined transfers go back to back.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready     = 1'b1;
        w_resp      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept = 1'b1;
            end
            ST_PEND: begin
                w_ready = 1'b0;
                if (bus.active_trans) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_ready  = bus.readyout_m;
                w_resp   = bus.resp_m;
                w_accept = bus.readyout_m;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_accept) begin
            if (w_live_req && bus.active_trans) begin
                w_state_nxt = ST_DATA;
            end else if (w_live_req) begin
                w_state_nxt = ST_PEND;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Address/control mux: held copy has priority over the live bus.
    always_comb begin
        if (r_held) begin
            bus.ADDR_M     = r_addr;
            bus.TRANS_M    = w_held_trans;
            bus.WRITE_M    = r_write;
            bus.SIZE_M     = r_size;
            bus.BURST_M    = r_burst;
            bus.PROT_M     = r_prot;
            bus.MASTLOCK_M = r_lock;
        end else begin
            bus.ADDR_M     = bus.HADDRS;
            bus.TRANS_M    = w_live_req ? bus.HTRANSS : TR_IDLE;
            bus.WRITE_M    = bus.HWRITES;
            bus.SIZE_M     = bus.HSIZES;
            bus.BURST_M    = bus.HBURSTS;
            bus.PROT_M     = bus.HPROTS;
            bus.MASTLOCK_M = bus.HMASTLOCKS;
        end
    end

    assign bus.sel_m      = r_held | w_live_req;
    assign bus.held_tran  = r_held;
    assign bus.HREADYOUTS = w_ready;
    assign bus.HRESPS     = w_resp;

endmodule
